// File: rtl/chan_mux.sv
// rtl/chan_mux.sv - registered N-channel word multiplexer with manual select and round-robin scan
module chan_mux #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 16,
    localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]           sel,
    input  logic                      sel_load,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out_val,
    output logic [SELW-1:0]           out_ch,
    output logic                      out_switch,
    output logic                      sel_err
);

    typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

    state_t           state_q;
    logic [SELW-1:0]  ch_q, ch_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] out_val_q;
    logic             out_switch_q;
    logic             sel_err_q;
    logic             sel_ok, load_ok, sel_err_d;

    logic [WIDTH-1:0] words [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_words
        assign words[k] = in_bus[k*WIDTH +: WIDTH];
    end

    always_comb begin
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        sel_ok    = (int'(sel) < CHANNELS);
        load_ok   = sel_load && !hold && sel_ok;
        sel_err_d = sel_load && !hold && !sel_ok;
        if (state_q == MANUAL) begin
            // Holding the counter at zero in manual makes every entry into scan start a fresh dwell.
            cnt_d = '0;
            if (load_ok) begin
                ch_d = sel;
            end
        end else if (!hold) begin
            if (load_ok) begin
                ch_d  = sel;
                cnt_d = '0;
            end else if (cnt_q == CNTW'(DWELL - 1)) begin
                cnt_d = '0;
                ch_d  = (ch_q == SELW'(CHANNELS - 1)) ? '0 : ch_q + SELW'(1);
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MANUAL;
            ch_q         <= '0;
            cnt_q        <= '0;
            out_val_q    <= '0;
            out_switch_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= mode ? SCAN : MANUAL;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            out_switch_q <= (ch_d != ch_q);
            sel_err_q    <= sel_err_d;
            if (!hold) begin
                out_val_q <= words[ch_d];
            end
        end
    end

    assign out_val    = out_val_q;
    assign out_ch     = ch_q;
    assign out_switch = out_switch_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_chan_mux.sv
// tb/tb_chan_mux.sv - randomized bench for chan_mux against a presentation-time reference model
module tb_chan_mux;

    localparam int WIDTH = 8;
    localparam int CH    = 5;
    localparam int DWELL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [39:0]   in_bus = '0;
    logic [2:0]    sel = '0;
    logic          sel_load = 1'b0;
    logic          mode = 1'b0;
    logic          hold = 1'b0;
    logic [7:0]    out_val;
    logic [2:0]    out_ch;
    logic          out_switch;
    logic          sel_err;

    int checks = 0;
    int errors = 0;

    // Reference: channel, cycles of presentation left, registered mode, expected outputs.
    bit         m_scan;
    int         m_ch;
    int         m_left;
    logic [7:0] m_val;
    bit         m_sw;
    bit         m_err;

    chan_mux #(.WIDTH(WIDTH), .CHANNELS(CH), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bus     (in_bus),
        .sel        (sel),
        .sel_load   (sel_load),
        .mode       (mode),
        .hold       (hold),
        .out_val    (out_val),
        .out_ch     (out_ch),
        .out_switch (out_switch),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 1'b0;
        m_ch   = 0;
        m_left = DWELL;
        m_val  = '0;
        m_sw   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        int nch;
        bit act;
        bit legal;
        nch   = m_ch;
        act   = sel_load && !hold;
        legal = act && (int'(sel) < CH);
        m_err = act && (int'(sel) >= CH);
        if (!m_scan) begin
            if (legal) nch = int'(sel);
            m_left = DWELL;
        end else if (!hold) begin
            if (legal) begin
                nch    = int'(sel);
                m_left = DWELL;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    nch    = (m_ch + 1) % CH;
                    m_left = DWELL;
                end
            end
        end
        m_sw = (nch != m_ch);
        m_ch = nch;
        if (!hold) m_val = in_bus[nch*8 +: 8];
        m_scan = mode;
    endtask

    task automatic cycle(input bit ld, input logic [2:0] s, input bit md, input bit hd,
                         input logic [39:0] bus);
        sel_load = ld;
        sel      = s;
        mode     = md;
        hold     = hd;
        in_bus   = bus;
        model_step();
        @(posedge clk);
        #1;
        check("out_val", 32'(out_val), 32'(m_val));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        check("out_switch", 32'(out_switch), 32'(m_sw));
        check("sel_err", 32'(sel_err), 32'(m_err));
    endtask

    function automatic logic [39:0] rnd_bus();
        return {8'($urandom), 32'($urandom)};
    endfunction

    logic [39:0] fixed_bus;
    logic [7:0]  frozen;
    int          run;
    int          ch_start;
    bit          found;

    initial begin
        fixed_bus = 40'h55_44_33_22_11;
        model_reset();
        in_bus = fixed_bus;
        #12;
        check("rst_out_val", 32'(out_val), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        check("rst_out_switch", 32'(out_switch), 32'h0);
        check("rst_sel_err", 32'(sel_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Manual select of channel 2.
        cycle(0, 3'd0, 0, 0, fixed_bus);
        cycle(1, 3'd2, 0, 0, fixed_bus);
        check("man_val", 32'(out_val), 32'h33);
        check("man_ch", 32'(out_ch), 32'd2);
        check("man_switch", 32'(out_switch), 32'd1);
        cycle(0, 3'd0, 0, 0, fixed_bus);
        check("man_switch_once", 32'(out_switch), 32'd0);
        cycle(1, 3'd2, 0, 0, fixed_bus);
        check("reload_same_no_switch", 32'(out_switch), 32'd0);

        // Illegal select leaves channel and data alone.
        cycle(1, 3'd6, 0, 0, fixed_bus);
        check("ill_err", 32'(sel_err), 32'd1);
        check("ill_ch", 32'(out_ch), 32'd2);
        check("ill_val", 32'(out_val), 32'h33);
        check("ill_switch", 32'(out_switch), 32'd0);
        cycle(0, 3'd0, 0, 0, fixed_bus);
        check("ill_err_once", 32'(sel_err), 32'd0);
        cycle(1, 3'd7, 0, 1, fixed_bus);
        check("held_no_err", 32'(sel_err), 32'd0);

        // Fresh scan from channel 0.
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 22; k++) begin
            cycle(0, 3'd0, 1, 0, fixed_bus);
            check("scan_seq", 32'(out_ch), 32'((k / DWELL) % CH));
        end

        // Hold for three cycles inside a dwell stretches that channel to seven samples.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 3'd0, 1, 0, rnd_bus());
            if (out_switch) found = 1;
        end
        check("hold_find_switch", 32'(found), 32'd1);
        ch_start = int'(out_ch);
        run = 1;
        cycle(0, 3'd0, 1, 0, rnd_bus());
        if (int'(out_ch) == ch_start) run++;
        frozen = out_val;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 3'd0, 1, 1, rnd_bus());
            if (int'(out_ch) == ch_start) run++;
            check("hold_frozen", 32'(out_val), 32'(frozen));
        end
        for (int i = 0; i < 20 && int'(out_ch) == ch_start; i++) begin
            cycle(0, 3'd0, 1, 0, rnd_bus());
            if (int'(out_ch) == ch_start) run++;
        end
        check("hold_run_len", 32'(run), 32'd7);

        // Legal load on the wrap cycle wins and restarts the dwell.
        for (int i = 0; i < 20 && m_left != 1; i++) cycle(0, 3'd0, 1, 0, rnd_bus());
        check("wrap_reached", 32'(m_left), 32'd1);
        cycle(1, 3'd1, 1, 0, rnd_bus());
        check("wrap_load_ch", 32'(out_ch), 32'd1);
        run = 1;
        for (int i = 0; i < 20 && out_ch == 3'd1; i++) begin
            cycle(0, 3'd0, 1, 0, rnd_bus());
            if (out_ch == 3'd1) run++;
        end
        check("wrap_run_len", 32'(run), 32'(DWELL));
        check("wrap_next_ch", 32'(out_ch), 32'd2);

        // Asynchronous reset while presenting channel 3.
        for (int i = 0; i < 40 && out_ch != 3'd3; i++) cycle(0, 3'd0, 1, 0, rnd_bus());
        check("rst_mid_on_ch3", 32'(out_ch), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_val", 32'(out_val), 32'h0);
        check("async_rst_ch", 32'(out_ch), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle(0, 3'd0, 1, 0, fixed_bus);
            check("post_rst_seq", 32'(out_ch), 32'((k / DWELL) % CH));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            cycle(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), mode,
                  ($urandom_range(0, 6) == 0), rnd_bus());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chan_mux.md
# chan_mux

Registered, parametrised N-channel by W-bit multiplexer for routing sensor or servo-command words onto a single shared bus. It selects one of CHANNELS input words either by explicit load (manual mode) or by automatic round-robin scanning with a programmable dwell time (scan mode). The output is registered and can be frozen. Status outputs report the active channel, channel switches and illegal selects. It sits between the per-leg data sources and a single downstream consumer, such as a PWM generator or serial link.

## Interface
- WIDTH, 8, bits per channel word
- CHANNELS, 4, number of input channels (2..16)
- DWELL, 16, cycles spent on each channel in scan mode (1..65535)
- SELW, derived as clog2(CHANNELS) (minimum 1), channel index width; not to be overridden

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_bus  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SELW  requested channel index
- sel_load  in  1  single-cycle strobe that captures sel
- mode  in  1  0 = manual, 1 = scan
- hold  in  1  freeze out_val and the dwell counter
- out_val  out  WIDTH  registered selected word
- out_ch  out  SELW  currently active channel
- out_switch  out  1  one-cycle pulse when out_ch changes
- sel_err  out  1  one-cycle pulse on an illegal sel_load

## Operation
- Reset (async assert, sync release): out_val=0, out_ch=0, out_switch=0, sel_err=0, dwell counter=0, state=MANUAL.
- States:
  - MANUAL when mode=0; SCAN when mode=1.
  - The state is re-evaluated every cycle from the registered mode.
  - On the MANUAL->SCAN transition the dwell counter clears. out_ch is unchanged.
- Manual: on sel_load with sel<CHANNELS, out_ch<=sel. With sel>=CHANNELS, out_ch is unchanged and sel_err pulses.
- Scan:
  - The dwell counter increments each cycle while hold=0.
  - When it reaches DWELL-1, it clears and out_ch advances by 1. Wrap is CHANNELS-1 -> 0.
  - A legal sel_load in SCAN loads out_ch<=sel and clears the dwell counter. This takes priority over a same-cycle advance.
  - An illegal sel_load in SCAN pulses sel_err. The scan proceeds normally.
- Output path:
  - out_val <= in_bus word indexed by the *next* out_ch value, every cycle while hold=0.
  - While hold=1, out_val, out_ch and the dwell counter are all frozen, and sel_load is ignored (no sel_err).
- out_switch pulses exactly when the registered out_ch value differs from its previous value. A reload of the same channel gives no pulse.
- DWELL=1: in scan mode the channel advances every non-held cycle.
- Dwell counter width: clog2(DWELL) bits, minimum 1.

## Timing
- Data latency: in_bus change to out_val is 1 cycle for the active channel.
- Select latency: sel_load at edge N gives out_ch and out_val of the new channel at edge N+1. out_switch is high in the cycle following edge N+1.
- Scan period: each channel is presented for exactly DWELL cycles when hold=0. Held cycles extend the period one for one.
- sel_err is registered, high for one cycle after the offending strobe.
- Mid-operation reset: all outputs return to reset values immediately and asynchronously. The first scan after release starts on channel 0 with the counter at 0.
- hold asserted in the same cycle as a scan wrap: no advance. The advance occurs on the first non-held cycle.

## Test plan
- Manual select, WIDTH=8, CHANNELS=4, in_bus words 0x11/0x22/0x33/0x44 -> sel_load sel=2 gives out_val=0x33 and out_ch=2 one cycle later, with a single out_switch pulse.
- Illegal select, CHANNELS=3, sel=3 -> sel_err pulses once; out_ch and out_val unchanged; no out_switch.
- Scan, DWELL=4, CHANNELS=4 -> out_ch sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0; out_switch every 4th cycle.
- Scan with hold high for 3 cycles mid-dwell -> that channel is presented for 7 cycles; out_val is frozen even though in_bus changes.
- sel_load sel=1 in SCAN on the wrap cycle -> out_ch=1, counter restarts; next advance to 2 occurs DWELL cycles later.
- rst_n pulsed low mid-scan on channel 3 -> out_val=0 and out_ch=0 asynchronously; scan resumes from channel 0 after release.
